// File: rtl/mem_lane_ctl.sv
// Data-side memory controller: splits CPU byte/half/word accesses onto four big-endian
// byte-lane RAM banks, traps misaligned accesses and returns extended load data one cycle later.
module mem_lane_ctl #(
  parameter int AW = 11
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW+1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic [31:0]   ram_wdata,
  output logic [AW-1:0] ram_wraddress,
  output logic [AW-1:0] ram_rdaddress,
  output logic [3:0]    ram_wren,
  input  logic [31:0]   ram_q,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          exc_misalign,
  output logic [AW+1:0] exc_addr
);

  // Byte offset k lives in lane 3-k (big-endian).
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      2'd3:    b = word[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  logic [1:0]    k_s;
  logic          legal_s;
  logic          accept_s;
  logic          trap_s;
  logic [3:0]    wren_s;
  logic [7:0]    byte_s;
  logic [15:0]   half_s;

  logic          ld_v_q, ld_v_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [1:0]    k_q, k_d;
  logic          exc_q, exc_d;
  logic [AW+1:0] exc_addr_q, exc_addr_d;

  assign k_s           = req_addr[1:0];
  assign ram_wraddress = req_addr[AW+1:2];
  assign ram_rdaddress = req_addr[AW+1:2];
  assign accept_s      = req_valid & legal_s;
  assign trap_s        = req_valid & ~legal_s;

  // Alignment check; size 3 is reserved and always traps.
  always_comb begin
    case (req_size)
      2'd0:    legal_s = 1'b1;
      2'd1:    legal_s = ~req_addr[0];
      2'd2:    legal_s = (req_addr[1:0] == 2'b00);
      default: legal_s = 1'b0;
    endcase
  end

  // Store lane steering; combinational because the banks register their inputs.
  always_comb begin
    wren_s    = 4'b0000;
    ram_wdata = req_wdata;
    case (req_size)
      2'd0: begin
        ram_wdata = {4{req_wdata[7:0]}};
        wren_s    = 4'b1000 >> k_s;
      end
      2'd1: begin
        ram_wdata = {2{req_wdata[15:0]}};
        wren_s    = k_s[1] ? 4'b0011 : 4'b1100;
      end
      2'd2: begin
        ram_wdata = req_wdata;
        wren_s    = 4'b1111;
      end
      default: begin
        ram_wdata = req_wdata;
        wren_s    = 4'b0000;
      end
    endcase
    if (rst_n && req_we && accept_s) begin
      ram_wren = wren_s;
    end else begin
      ram_wren = 4'b0000;
    end
  end

  // Next state for the load stage and the trap registers.
  always_comb begin
    ld_v_d     = accept_s & ~req_we;
    size_d     = size_q;
    uns_d      = uns_q;
    k_d        = k_q;
    exc_d      = trap_s;
    exc_addr_d = exc_addr_q;
    if (accept_s && !req_we) begin
      size_d = req_size;
      uns_d  = req_unsigned;
      k_d    = k_s;
    end else begin
      size_d = size_q;
    end
    if (trap_s) begin
      exc_addr_d = req_addr;
    end else begin
      exc_addr_d = exc_addr_q;
    end
  end

  // Stage and trap registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ld_v_q     <= 1'b0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      k_q        <= 2'd0;
      exc_q      <= 1'b0;
      exc_addr_q <= '0;
    end else begin
      ld_v_q     <= ld_v_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      k_q        <= k_d;
      exc_q      <= exc_d;
      exc_addr_q <= exc_addr_d;
    end
  end

  assign rsp_valid    = ld_v_q;
  assign exc_misalign = exc_q;
  assign exc_addr     = exc_addr_q;
  assign byte_s       = lane_byte(ram_q, k_q);
  assign half_s       = k_q[1] ? ram_q[15:0] : ram_q[31:16];

  // Load alignment and extension straight off the bank outputs.
  always_comb begin
    case (size_q)
      2'd0:    rsp_rdata = {{24{~uns_q & byte_s[7]}}, byte_s};
      2'd1:    rsp_rdata = {{16{~uns_q & half_s[15]}}, half_s};
      2'd2:    rsp_rdata = ram_q;
      default: rsp_rdata = 32'h0000_0000;
    endcase
    if (!ld_v_q) begin
      rsp_rdata = 32'h0000_0000;
    end else begin
      rsp_rdata = rsp_rdata;
    end
  end

endmodule

// File: tb/tb_mem_lane_ctl.sv
// Directed plus random bench for mem_lane_ctl with a behavioural bank model and a
// byte-addressed reference memory.
module tb_mem_lane_ctl;
  localparam int AW = 11;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          req_valid, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AW+1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [31:0]   ram_wdata, ram_q, rsp_rdata;
  logic [AW-1:0] ram_wraddress, ram_rdaddress;
  logic [3:0]    ram_wren;
  logic          rsp_valid, exc_misalign;
  logic [AW+1:0] exc_addr;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0]    ref_mem [8192];
  logic [AW+1:0] exp_exc_addr;

  mem_lane_ctl #(.AW(AW)) dut (
    .clock(clock), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .ram_wdata(ram_wdata), .ram_wraddress(ram_wraddress),
    .ram_rdaddress(ram_rdaddress), .ram_wren(ram_wren), .ram_q(ram_q),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .exc_misalign(exc_misalign),
    .exc_addr(exc_addr)
  );

  always #5 clock = ~clock;

  // Four registered-input byte banks.
  logic [7:0]    bank [4][2048];
  logic [3:0]    wr_en_r;
  logic [AW-1:0] wa_r, ra_r;
  logic [31:0]   wd_r;
  always @(posedge clock) begin
    for (int i = 0; i < 4; i++)
      if (wr_en_r[i]) bank[i][wa_r] <= wd_r[8*i +: 8];
    wr_en_r <= ram_wren;
    wa_r    <= ram_wraddress;
    wd_r    <= ram_wdata;
    ra_r    <= ram_rdaddress;
  end
  assign ram_q = {bank[3][ra_r], bank[2][ra_r], bank[1][ra_r], bank[0][ra_r]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic legal(input logic [1:0] sz, input int a);
    if (sz == 2'd3) return 1'b0;
    return (a % (1 << sz)) == 0;
  endfunction

  // One request cycle: check same-cycle store outputs, then next-cycle response/trap.
  task automatic cycle(input logic v, input logic we, input logic [1:0] sz,
                       input logic uns, input int a, input logic [31:0] wd);
    logic lg, exp_v;
    int n, kk;
    logic [3:0]  en;
    logic [31:0] ew, tmp, ld;
    req_valid = v; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a[AW+1:0]; req_wdata = wd;
    #1;
    lg = legal(sz, a);
    n  = 1 << sz;
    chk("rdaddr", {21'd0, ram_rdaddress}, a / 4);
    en = 4'b0000;
    if (v && we && lg)
      for (int j = 0; j < n; j++) en[3 - ((a + j) % 4)] = 1'b1;
    chk("wren", {28'd0, ram_wren}, {28'd0, en});
    if (v && we && lg) begin
      chk("wraddr", {21'd0, ram_wraddress}, a / 4);
      for (int l = 0; l < 4; l++) begin
        kk  = 3 - l;
        tmp = wd >> (8 * (n - 1 - (kk % n)));
        ew[8*l +: 8] = tmp[7:0];
      end
      chk("wdata", ram_wdata, ew);
      for (int j = 0; j < n; j++) begin
        tmp = wd >> (8 * (n - 1 - j));
        ref_mem[a + j] = tmp[7:0];
      end
    end
    exp_v = v && !we && lg;
    ld = 32'd0;
    if (exp_v) begin
      for (int j = 0; j < n; j++) ld = (ld << 8) | {24'd0, ref_mem[a + j]};
      if (n < 4 && !uns && ld[8*n-1]) ld = ld | (32'hFFFF_FFFF << (8 * n));
    end
    if (v && !lg) exp_exc_addr = a[AW+1:0];
    @(posedge clock); #1;
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_v});
    chk("rsp_rdata", rsp_rdata, ld);
    chk("exc_misalign", {31'd0, exc_misalign}, {31'd0, v && !lg});
    chk("exc_addr", {19'd0, exc_addr}, {19'd0, exp_exc_addr});
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'h00;
    exp_exc_addr = '0;
    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = 32'hFFFF_FFFF;
    #1;
    chk("rst_wren", {28'd0, ram_wren}, 32'd0);
    @(posedge clock); @(posedge clock); #1;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_exc", {31'd0, exc_misalign}, 32'd0);
    chk("rst_exc_addr", {19'd0, exc_addr}, 32'd0);
    req_valid = 1'b0;
    rst_n = 1'b1;

    // Clear the words used by the random phase so bank and reference agree.
    for (int w = 0; w < 16; w++) cycle(1, 1, 2, 0, 4 * w, 32'd0);

    cycle(1, 1, 2, 0, 'h010, 32'h1234_5678);   // sw
    cycle(1, 0, 2, 0, 'h010, 32'd0);           // lw next cycle sees new data
    cycle(1, 1, 0, 0, 'h013, 32'h0000_00A5);   // sb
    cycle(1, 0, 0, 0, 'h013, 32'd0);           // lb
    cycle(1, 0, 0, 1, 'h013, 32'd0);           // lbu
    cycle(1, 1, 1, 0, 'h022, 32'h0000_8001);   // sh
    cycle(1, 0, 1, 0, 'h022, 32'd0);           // lh
    cycle(1, 0, 1, 1, 'h020, 32'd0);           // lhu upper half
    cycle(1, 0, 2, 0, 'h021, 32'd0);           // misaligned lw
    cycle(1, 1, 1, 0, 'h003, 32'h0000_BEEF);   // misaligned sh
    cycle(1, 0, 3, 0, 'h014, 32'd0);           // reserved size
    cycle(0, 0, 0, 0, 'h000, 32'd0);           // trap pulse must end, exc_addr holds
    cycle(1, 1, 2, 0, 'h000, 32'h3C1C_0000);
    for (int b = 0; b < 4; b++) cycle(1, 0, 0, 1, b, 32'd0);

    // Reset in the middle of a load, with a store presented while in reset.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 'h010;
    #2; rst_n = 1'b0; #1;
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_exc_addr", {19'd0, exc_addr}, 32'd0);
    req_we = 1'b1; req_wdata = 32'hDEAD_BEEF; #1;
    chk("mid_rst_wren", {28'd0, ram_wren}, 32'd0);
    @(posedge clock); #1;
    req_valid = 1'b0;
    rst_n = 1'b1;
    exp_exc_addr = '0;
    chk("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    cycle(1, 0, 2, 0, 'h010, 32'd0);
    cycle(1, 0, 2, 0, 'h000, 32'd0);

    for (int r = 0; r < 300; r++)
      cycle($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
